id_decode_queue: RTL and testbench

Buffered instruction-decode stage between fetch and execute. Accepts fetched instruction/PC pairs over a valid/ready handshake and decodes each on entry: immediate, register/CSR write enables, and illegal-instruction flag. Stores the decoded results in a DEPTH-entry FIFO and presents the head entry to execute over a second valid/ready handshake. A synchronous flush discards all contents on branch, trap or mret redirect.

---
 rtl/id_decode_queue_if.sv | 65 ++++++
 rtl/id_decode_queue.sv | 238 +++++++++++++++++++++++
 tb/tb_id_decode_queue.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_decode_queue_if.sv
// rtl/id_decode_queue_if.sv - fetch-side and execute-side handshake bundle for id_decode_queue
interface id_decode_queue_if #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Redirect (branch, trap, mret) discard
   logic             flush;

   // Fetch side
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_ir;
   logic [PC_W-1:0]  in_pc;

   // Execute side
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_ir;
   logic [PC_W-1:0]  out_pc;
   logic [31:0]      out_imm;
   logic             out_wr_reg_n;
   logic             out_wr_csr_n;
   logic             out_illegal;

   // Occupancy
   logic [CNT_W-1:0] count;

   // Decode queue view
   modport slave (
      input  flush,
      input  in_valid,
      output in_ready,
      input  in_ir,
      input  in_pc,
      output out_valid,
      input  out_ready,
      output out_ir,
      output out_pc,
      output out_imm,
      output out_wr_reg_n,
      output out_wr_csr_n,
      output out_illegal,
      output count
   );

   // Fetch/execute/redirect view
   modport master (
      output flush,
      output in_valid,
      input  in_ready,
      output in_ir,
      output in_pc,
      input  out_valid,
      output out_ready,
      input  out_ir,
      input  out_pc,
      input  out_imm,
      input  out_wr_reg_n,
      input  out_wr_csr_n,
      input  out_illegal,
      input  count
   );
endinterface

// File: rtl/id_decode_queue.sv
// rtl/id_decode_queue.sv - decode-on-entry instruction queue between fetch and execute (optional RV32M_EN)
module id_decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input logic              clk,
   input logic              rst,
   id_decode_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] IR_ECALL = 32'h0000_0073;
   localparam logic [31:0] IR_MRET  = 32'h3020_0073;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Instruction fields of the incoming word
   logic [6:0] w_opcode;
   logic [4:0] w_rd;
   logic [2:0] w_funct3;
   logic [4:0] w_rs1;
   logic [6:0] w_funct7;

   assign w_opcode = bus.in_ir[6:0];
   assign w_rd     = bus.in_ir[11:7];
   assign w_funct3 = bus.in_ir[14:12];
   assign w_rs1    = bus.in_ir[19:15];
   assign w_funct7 = bus.in_ir[31:25];

   // Immediate formats
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic [31:0] w_imm_shamt;
   logic [31:0] w_imm_csr;

   assign w_imm_i     = {{20{bus.in_ir[31]}}, bus.in_ir[31:20]};
   assign w_imm_s     = {{20{bus.in_ir[31]}}, bus.in_ir[31:25], bus.in_ir[11:7]};
   assign w_imm_b     = {{20{bus.in_ir[31]}}, bus.in_ir[7], bus.in_ir[30:25], bus.in_ir[11:8], 1'b0};
   assign w_imm_u     = {bus.in_ir[31:12], 12'b0};
   assign w_imm_j     = {{12{bus.in_ir[31]}}, bus.in_ir[19:12], bus.in_ir[20], bus.in_ir[30:21], 1'b0};
   assign w_imm_shamt = {27'b0, bus.in_ir[24:20]};
   assign w_imm_csr   = {20'b0, bus.in_ir[31:20]};

   // Multiply/divide group on the OP opcode
   logic w_op_muldiv;
`ifdef RV32M_EN
   assign w_op_muldiv = (w_funct7 == 7'b0000001);
`else
   assign w_op_muldiv = 1'b0;
`endif

   // Decoder results for the incoming word
   logic [31:0] w_dec_imm;
   logic        w_dec_illegal;
   logic        w_rd_class;
   logic        w_csr_class;
   logic        w_dec_wr_reg_n;
   logic        w_dec_wr_csr_n;

   // Per-opcode immediate selection, legality and write-class classification
   always_comb begin
      w_dec_imm     = 32'b0;
      w_dec_illegal = 1'b0;
      w_rd_class    = 1'b0;
      w_csr_class   = 1'b0;
      case (w_opcode)
         OPC_LUI, OPC_AUIPC: begin
            w_dec_imm  = w_imm_u;
            w_rd_class = 1'b1;
         end
         OPC_JAL: begin
            w_dec_imm  = w_imm_j;
            w_rd_class = 1'b1;
         end
         OPC_JALR: begin
            w_dec_imm     = w_imm_i;
            w_rd_class    = 1'b1;
            w_dec_illegal = (w_funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            w_dec_imm     = w_imm_b;
            w_dec_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
         end
         OPC_LOAD: begin
            w_dec_imm     = w_imm_i;
            w_rd_class    = 1'b1;
            w_dec_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
         end
         OPC_STORE: begin
            w_dec_imm     = w_imm_s;
            w_dec_illegal = (w_funct3 > 3'b010);
         end
         OPC_OP_IMM: begin
            w_rd_class = 1'b1;
            if (w_funct3 == 3'b001) begin
               // SLLI: only the plain encoding exists
               w_dec_imm     = w_imm_shamt;
               w_dec_illegal = (w_funct7 != F7_ZERO);
            end else if (w_funct3 == 3'b101) begin
               // SRLI/SRAI share funct3; funct7 picks logical vs arithmetic
               w_dec_imm     = w_imm_shamt;
               w_dec_illegal = (w_funct7 != F7_ZERO) && (w_funct7 != F7_ALT);
            end else begin
               w_dec_imm = w_imm_i;
            end
         end
         OPC_OP: begin
            w_rd_class = 1'b1;
            if ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)) begin
               // ADD/SUB and SRL/SRA allow the alternate funct7
               w_dec_illegal = (w_funct7 != F7_ZERO) && (w_funct7 != F7_ALT) && !w_op_muldiv;
            end else begin
               w_dec_illegal = (w_funct7 != F7_ZERO) && !w_op_muldiv;
            end
         end
         OPC_SYSTEM: begin
            w_dec_imm = w_imm_csr;
            if (w_funct3 == 3'b000) begin
               w_dec_illegal = (bus.in_ir != IR_ECALL) && (bus.in_ir != IR_MRET);
            end else if (w_funct3 == 3'b100) begin
               w_dec_illegal = 1'b1;
            end else begin
               // CSR access: a CSRRS with rs1=x0 is a pure read
               w_rd_class  = 1'b1;
               w_csr_class = !((w_funct3 == 3'b010) && (w_rs1 == 5'd0));
            end
         end
         default: begin
            w_dec_illegal = 1'b1;
         end
      endcase
   end

   assign w_dec_wr_reg_n = !(!w_dec_illegal && (w_rd != 5'd0) && w_rd_class);
   assign w_dec_wr_csr_n = !(!w_dec_illegal && w_csr_class);

   // Queue state
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic [31:0]     r_ir_mem    [DEPTH];
   logic [PC_W-1:0] r_pc_mem    [DEPTH];
   logic [31:0]     r_imm_mem   [DEPTH];
   logic            r_wrreg_mem [DEPTH];
   logic            r_wrcsr_mem [DEPTH];
   logic            r_ill_mem   [DEPTH];

   logic w_in_ready;
   logic w_out_valid;
   logic w_push;
   logic w_pop;

   assign w_in_ready  = (r_count < CNT_FULL);
   assign w_out_valid = (r_count != '0);
   assign w_push      = bus.in_valid && w_in_ready && !bus.flush;
   assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;

   // Pointer and occupancy update; flush wins over any push or pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (bus.flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_ONE;
         end
         if (w_pop) begin
            r_head <= r_head + PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // Entry storage captures the decoded record at the tail on push
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ir_mem[r_tail]    <= bus.in_ir;
         r_pc_mem[r_tail]    <= bus.in_pc;
         r_imm_mem[r_tail]   <= w_dec_imm;
         r_wrreg_mem[r_tail] <= w_dec_wr_reg_n;
         r_wrcsr_mem[r_tail] <= w_dec_wr_csr_n;
         r_ill_mem[r_tail]   <= w_dec_illegal;
      end
   end

   // Head presentation, forced to idle values while the queue is empty
   always_comb begin
      bus.out_ir       = 32'b0;
      bus.out_pc       = '0;
      bus.out_imm      = 32'b0;
      bus.out_wr_reg_n = 1'b1;
      bus.out_wr_csr_n = 1'b1;
      bus.out_illegal  = 1'b0;
      if (w_out_valid) begin
         bus.out_ir       = r_ir_mem[r_head];
         bus.out_pc       = r_pc_mem[r_head];
         bus.out_imm      = r_imm_mem[r_head];
         bus.out_wr_reg_n = r_wrreg_mem[r_head];
         bus.out_wr_csr_n = r_wrcsr_mem[r_head];
         bus.out_illegal  = r_ill_mem[r_head];
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.count     = r_count;

endmodule

// File: tb/tb_id_decode_queue.sv
// tb/tb_id_decode_queue.sv - scoreboard bench for id_decode_queue
module tb_id_decode_queue;
   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int NT    = 20;

`ifdef RV32M_EN
   localparam logic MUL_ILL = 1'b0;
`else
   localparam logic MUL_ILL = 1'b1;
`endif

   // Decode table: instruction word and hand-derived {imm, wr_reg_n, wr_csr_n, illegal}
   localparam logic [31:0] T_IR [NT] = '{
      32'h00500093, 32'h02208033, 32'h30200073, 32'h00002573, 32'h00004073,
      32'h123452B7, 32'hFFDFF0EF, 32'h00000463, 32'hFE20AE23, 32'h4071D193,
      32'h40111093, 32'hFFF02283, 32'h00003283, 32'h000010E7, 32'h0000000B,
      32'h300110F3, 32'h402081B3, 32'h4020F1B3, 32'h00002463, 32'h00000073
   };
   localparam logic [34:0] T_EXP [NT] = '{
      {32'h00000005, 1'b0, 1'b1, 1'b0},
      {32'h00000000, 1'b1, 1'b1, MUL_ILL},
      {32'h00000302, 1'b1, 1'b1, 1'b0},
      {32'h00000000, 1'b0, 1'b1, 1'b0},
      {32'h00000000, 1'b1, 1'b1, 1'b1},
      {32'h12345000, 1'b0, 1'b1, 1'b0},
      {32'hFFFFFFFC, 1'b0, 1'b1, 1'b0},
      {32'h00000008, 1'b1, 1'b1, 1'b0},
      {32'hFFFFFFFC, 1'b1, 1'b1, 1'b0},
      {32'h00000007, 1'b0, 1'b1, 1'b0},
      {32'h00000001, 1'b1, 1'b1, 1'b1},
      {32'hFFFFFFFF, 1'b0, 1'b1, 1'b0},
      {32'h00000000, 1'b1, 1'b1, 1'b1},
      {32'h00000000, 1'b1, 1'b1, 1'b1},
      {32'h00000000, 1'b1, 1'b1, 1'b1},
      {32'h00000300, 1'b0, 1'b0, 1'b0},
      {32'h00000000, 1'b0, 1'b1, 1'b0},
      {32'h00000000, 1'b1, 1'b1, 1'b1},
      {32'h00000008, 1'b1, 1'b1, 1'b1},
      {32'h00000000, 1'b1, 1'b1, 1'b0}
   };

   typedef struct packed {
      logic [31:0]     ir;
      logic [PC_W-1:0] pc;
      logic [31:0]     imm;
      logic            reg_n;
      logic            csr_n;
      logic            ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   id_decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

   id_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb[$];
   exp_t cur;
   exp_t exp_e;
   exp_t got;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic set_in(input logic v, input logic [31:0] ir, input logic [PC_W-1:0] pc,
                         input logic [31:0] imm, input logic rn, input logic cn, input logic il);
      bus.in_valid = v;
      bus.in_ir    = ir;
      bus.in_pc    = pc;
      cur.ir       = ir;
      cur.pc       = pc;
      cur.imm      = imm;
      cur.reg_n    = rn;
      cur.csr_n    = cn;
      cur.ill      = il;
   endtask

   // One clock: scoreboard pop/compare and push at the negedge, then advance past the edge
   task automatic cycle();
      @(negedge clk);
      if (bus.flush) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            got.ir    = bus.out_ir;
            got.pc    = bus.out_pc;
            got.imm   = bus.out_imm;
            got.reg_n = bus.out_wr_reg_n;
            got.csr_n = bus.out_wr_csr_n;
            got.ill   = bus.out_illegal;
            if (sb.size() == 0) begin
               $display("FAIL scoreboard_pop: dut presented pc=%h with nothing expected", bus.out_pc);
            end else begin
               exp_e = sb.pop_front();
               if (got !== exp_e)
                  $display("FAIL scoreboard_entry: got ir=%h pc=%h imm=%h rn/cn/il=%b%b%b expected ir=%h pc=%h imm=%h rn/cn/il=%b%b%b",
                           got.ir, got.pc, got.imm, got.reg_n, got.csr_n, got.ill,
                           exp_e.ir, exp_e.pc, exp_e.imm, exp_e.reg_n, exp_e.csr_n, exp_e.ill);
               else
                  n_pass++;
            end
         end
         if (bus.in_valid && bus.in_ready) sb.push_back(cur);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({bus.in_ready, bus.out_valid, bus.count} !== {1'b1, 1'b0, CNT_W'(0)})
         $display("FAIL reset_handshake: got rdy/vld/cnt=%b/%b/%0d expected 1/0/0", bus.in_ready, bus.out_valid, bus.count);
      else n_pass++;
      n_checks++;
      if ({bus.out_ir, bus.out_pc, bus.out_imm} !== {32'h0, 32'h0, 32'h0})
         $display("FAIL reset_data: got ir=%h pc=%h imm=%h expected all zero", bus.out_ir, bus.out_pc, bus.out_imm);
      else n_pass++;
      n_checks++;
      if ({bus.out_wr_reg_n, bus.out_wr_csr_n, bus.out_illegal} !== 3'b110)
         $display("FAIL reset_flags: got %b expected 110", {bus.out_wr_reg_n, bus.out_wr_csr_n, bus.out_illegal});
      else n_pass++;
   endtask

   task automatic test_first_push();
      bus.out_ready = 1'b0;
      set_in(1'b1, 32'h00500093, 32'h100, 32'h5, 1'b0, 1'b1, 1'b0);
      cycle();
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({bus.out_valid, bus.out_imm, bus.out_wr_reg_n, bus.out_illegal} !== {1'b1, 32'h5, 1'b0, 1'b0})
         $display("FAIL first_push: got vld=%b imm=%h rn=%b il=%b expected 1/00000005/0/0",
                  bus.out_valid, bus.out_imm, bus.out_wr_reg_n, bus.out_illegal);
      else n_pass++;
      bus.out_ready = 1'b1;
      cycle();
      bus.out_ready = 1'b0;
      n_checks++;
      if ({bus.out_valid, bus.count} !== {1'b0, CNT_W'(0)})
         $display("FAIL first_pop_empty: got vld=%b cnt=%0d expected 0/0", bus.out_valid, bus.count);
      else n_pass++;
   endtask

   task automatic test_fill_wrap();
      for (int k = 0; k < DEPTH; k++) begin
         set_in(1'b1, 32'h00500093, 32'h200 + 32'(4 * k), 32'h5, 1'b0, 1'b1, 1'b0);
         cycle();
      end
      n_checks++;
      if ({bus.in_ready, bus.count} !== {1'b0, CNT_W'(DEPTH)})
         $display("FAIL fill_full: got rdy=%b cnt=%0d expected 0/%0d", bus.in_ready, bus.count, DEPTH);
      else n_pass++;
      set_in(1'b1, 32'h00A00093, 32'h300, 32'hA, 1'b0, 1'b1, 1'b0);
      cycle();
      n_checks++;
      if ({bus.in_ready, bus.count} !== {1'b0, CNT_W'(DEPTH)})
         $display("FAIL fill_ignore_extra: got rdy=%b cnt=%0d expected 0/%0d", bus.in_ready, bus.count, DEPTH);
      else n_pass++;
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) cycle();
      bus.out_ready = 1'b0;
      n_checks++;
      if ({bus.out_valid, bus.count, 32'(sb.size())} !== {1'b0, CNT_W'(0), 32'd0})
         $display("FAIL drain_wrap: got vld=%b cnt=%0d pending=%0d expected 0/0/0", bus.out_valid, bus.count, sb.size());
      else n_pass++;
   endtask

   task automatic test_full_push_pop();
      for (int k = 0; k < DEPTH; k++) begin
         set_in(1'b1, 32'h00500093, 32'h400 + 32'(4 * k), 32'h5, 1'b0, 1'b1, 1'b0);
         cycle();
      end
      set_in(1'b1, 32'h00A00093, 32'h500, 32'hA, 1'b0, 1'b1, 1'b0);
      bus.out_ready = 1'b1;
      cycle();
      n_checks++;
      if (bus.count !== CNT_W'(DEPTH - 1))
         $display("FAIL full_push_pop: got cnt=%0d expected %0d", bus.count, DEPTH - 1);
      else n_pass++;
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < DEPTH - 1; k++) cycle();
      bus.out_ready = 1'b0;
      n_checks++;
      if ({bus.count, 32'(sb.size())} !== {CNT_W'(0), 32'd0})
         $display("FAIL full_drain: got cnt=%0d pending=%0d expected 0/0", bus.count, sb.size());
      else n_pass++;
   endtask

   task automatic test_half_push_pop();
      for (int k = 0; k < DEPTH / 2; k++) begin
         set_in(1'b1, 32'h00500093, 32'h600 + 32'(4 * k), 32'h5, 1'b0, 1'b1, 1'b0);
         cycle();
      end
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 32'hFFF02283, 32'h700 + 32'(4 * k), 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
         cycle();
         n_checks++;
         if (bus.count !== CNT_W'(DEPTH / 2))
            $display("FAIL half_push_pop: got cnt=%0d expected %0d", bus.count, DEPTH / 2);
         else n_pass++;
      end
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < DEPTH / 2; k++) cycle();
      bus.out_ready = 1'b0;
      n_checks++;
      if ({bus.count, 32'(sb.size())} !== {CNT_W'(0), 32'd0})
         $display("FAIL half_drain: got cnt=%0d pending=%0d expected 0/0", bus.count, sb.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int i = 0; i < NT; i++) begin
         set_in(1'b1, T_IR[i], 32'h1000 + 32'(4 * i), T_EXP[i][34:3], T_EXP[i][2], T_EXP[i][1], T_EXP[i][0]);
         cycle();
         n_checks++;
         if (bus.count !== CNT_W'(1))
            $display("FAIL stream_count: entry %0d got cnt=%0d expected 1", i, bus.count);
         else n_pass++;
      end
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      cycle();
      cycle();
      bus.out_ready = 1'b0;
      n_checks++;
      if ({bus.count, 32'(sb.size())} !== {CNT_W'(0), 32'd0})
         $display("FAIL stream_drain: got cnt=%0d pending=%0d expected 0/0", bus.count, sb.size());
      else n_pass++;
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 32'h00500093, 32'h800 + 32'(4 * k), 32'h5, 1'b0, 1'b1, 1'b0);
         cycle();
      end
      n_checks++;
      if (bus.count !== CNT_W'(3))
         $display("FAIL flush_prefill: got cnt=%0d expected 3", bus.count);
      else n_pass++;
      set_in(1'b1, 32'h00A00093, 32'h880, 32'hA, 1'b0, 1'b1, 1'b0);
      bus.flush = 1'b1;
      cycle();
      bus.flush = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({bus.count, bus.out_valid, bus.in_ready, bus.out_pc} !== {CNT_W'(0), 1'b0, 1'b1, 32'h0})
         $display("FAIL flush_clear: got cnt=%0d vld=%b rdy=%b pc=%h expected 0/0/1/00000000",
                  bus.count, bus.out_valid, bus.in_ready, bus.out_pc);
      else n_pass++;
      cycle();
      n_checks++;
      if (bus.count !== CNT_W'(0))
         $display("FAIL flush_input_dropped: got cnt=%0d expected 0", bus.count);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         set_in(1'b1, 32'h300110F3, 32'h900 + 32'(4 * k), 32'h300, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.count} !== {1'b0, 1'b1, CNT_W'(0)})
         $display("FAIL async_reset_handshake: got vld/rdy/cnt=%b/%b/%0d expected 0/1/0", bus.out_valid, bus.in_ready, bus.count);
      else n_pass++;
      n_checks++;
      if ({bus.out_ir, bus.out_imm, bus.out_wr_reg_n, bus.out_wr_csr_n, bus.out_illegal} !== {32'h0, 32'h0, 3'b110})
         $display("FAIL async_reset_data: got ir=%h imm=%h flags=%b expected 0/0/110",
                  bus.out_ir, bus.out_imm, {bus.out_wr_reg_n, bus.out_wr_csr_n, bus.out_illegal});
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      set_in(1'b1, 32'h00500093, 32'h980, 32'h5, 1'b0, 1'b1, 1'b0);
      cycle();
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      cycle();
      bus.out_ready = 1'b0;
      n_checks++;
      if ({bus.count, 32'(sb.size())} !== {CNT_W'(0), 32'd0})
         $display("FAIL post_reset_roundtrip: got cnt=%0d pending=%0d expected 0/0", bus.count, sb.size());
      else n_pass++;
   endtask

   initial begin
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      test_first_push();
      test_fill_wrap();
      test_full_push_pop();
      test_half_push_pop();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
